dcache_rr_tag_arbiter: RTL and testbench

// - Parametrised successor to the fixed-priority dcache tag-compare/arbiter: arbitrates NumPorts

---
 rtl/dcache_rr_tag_arbiter.sv | 144 ++++++++++++++
 tb/tb_dcache_rr_tag_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_rr_tag_arbiter.sv
// Round-robin arbiter of NumPorts requesters onto SetAssoc tag/data SRAM ways, port-0 priority with starvation guard.
// Grant is combinational, read data and one-hot hit way follow one cycle later; losers simply keep requesting (no queueing).
module dcache_rr_tag_arbiter #(
    parameter int NumPorts    = 5,
    parameter int SetAssoc    = 8,
    parameter int IndexWidth  = 12,
    parameter int TagWidth    = 44,
    parameter int LineWidth   = 128,
    parameter bit PrioPort0   = 1'b1,
    parameter int StarveLimit = 4,
    localparam int EW = 2 + TagWidth + LineWidth,
    localparam int BW = LineWidth / 8 + 2
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumPorts-1:0][SetAssoc-1:0]   req_i,
    input  logic [NumPorts-1:0][IndexWidth-1:0] addr_i,
    input  logic [NumPorts-1:0]                 we_i,
    input  logic [NumPorts-1:0][EW-1:0]         wdata_i,
    input  logic [NumPorts-1:0][BW-1:0]         be_i,
    input  logic [NumPorts-1:0][TagWidth-1:0]   tag_i,
    output logic [NumPorts-1:0]                 gnt_o,
    output logic [NumPorts-1:0]                 rvalid_o,
    output logic [SetAssoc-1:0][EW-1:0]         rdata_o,
    output logic [SetAssoc-1:0]                 hit_way_o,
    output logic [SetAssoc-1:0]                 sram_req_o,
    output logic [IndexWidth-1:0]               sram_addr_o,
    output logic                                sram_we_o,
    output logic [EW-1:0]                       sram_wdata_o,
    output logic [BW-1:0]                       sram_be_o,
    input  logic [SetAssoc-1:0][EW-1:0]         sram_rdata_i
);
    localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int CW = $clog2(StarveLimit + 1);

    logic [PW-1:0]                 rr_q, rr_d;
    logic [NumPorts-1:0][CW-1:0]   starve_q, starve_d;
    logic [NumPorts-1:0]           rvalid_q, rvalid_d;
    logic [PW-1:0]                 id_q, id_d;
    logic [NumPorts-1:0]           cand, starved, scan_mask;
    logic [PW-1:0]                 win;
    logic                          win_vld;
    logic [PW:0]                   idx;
    logic [PW:0]                   nxt;

    always_comb begin
        cand      = '0;
        starved   = '0;
        scan_mask = '0;
        win       = '0;
        win_vld   = 1'b0;
        idx       = '0;
        for (int i = 0; i < NumPorts; i++) begin
            cand[i]    = |req_i[i];
            starved[i] = (i != 0) && cand[i] && (starve_q[i] == CW'(StarveLimit));
        end
        // When port 0 contends with priority, only starved ports may beat it.
        scan_mask = (PrioPort0 && cand[0]) ? starved : cand;
        if (PrioPort0) begin
            scan_mask[0] = 1'b0;
        end
        if (PrioPort0 && cand[0] && !(|starved)) begin
            win_vld = 1'b1;
        end else begin
            for (int k = 0; k < NumPorts; k++) begin
                idx = {1'b0, rr_q} + (PW+1)'(k);
                if (idx >= (PW+1)'(NumPorts)) begin
                    idx = idx - (PW+1)'(NumPorts);
                end
                if (!win_vld && scan_mask[idx[PW-1:0]]) begin
                    win_vld = 1'b1;
                    win     = idx[PW-1:0];
                end
            end
        end
        if (rst_i) begin
            win_vld = 1'b0;
        end
        gnt_o = '0;
        if (win_vld) begin
            gnt_o[win] = 1'b1;
        end
    end

    assign sram_req_o   = win_vld ? req_i[win] : '0;
    assign sram_we_o    = win_vld && we_i[win];
    assign sram_addr_o  = addr_i[win];
    assign sram_wdata_o = wdata_i[win];
    assign sram_be_o    = be_i[win];

    always_comb begin
        rr_d     = rr_q;
        nxt      = '0;
        starve_d = '0;
        rvalid_d = '0;
        id_d     = id_q;
        if (win_vld && (win != '0 || !PrioPort0)) begin
            nxt = {1'b0, win} + (PW+1)'(1);
            if (nxt >= (PW+1)'(NumPorts)) begin
                nxt = PrioPort0 ? (PW+1)'(1) : '0;
            end
            rr_d = nxt[PW-1:0];
        end
        for (int i = 1; i < NumPorts; i++) begin
            if (cand[i] && !gnt_o[i]) begin
                starve_d[i] = (starve_q[i] == CW'(StarveLimit)) ? starve_q[i] : starve_q[i] + CW'(1);
            end
        end
        if (win_vld && !we_i[win]) begin
            rvalid_d = gnt_o;
            id_d     = win;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q     <= PW'(1);
            starve_q <= '0;
            rvalid_q <= '0;
            id_q     <= '0;
        end else begin
            rr_q     <= rr_d;
            starve_q <= starve_d;
            rvalid_q <= rvalid_d;
            id_q     <= id_d;
        end
    end

    // Gating with rst_i keeps a read granted just before reset from surfacing.
    assign rvalid_o = rst_i ? '0 : rvalid_q;
    assign rdata_o  = sram_rdata_i;

    always_comb begin
        hit_way_o = '0;
        for (int w = 0; w < SetAssoc; w++) begin
            hit_way_o[w] = (|rvalid_o) && rdata_o[w][EW-1] &&
                           (rdata_o[w][EW-3 -: TagWidth] == tag_i[id_q]);
        end
    end

    a_hit_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(hit_way_o))
        else $error("multiple ways hit the same tag");

endmodule

// File: tb/tb_dcache_rr_tag_arbiter.sv
// Bench for dcache_rr_tag_arbiter: directed scenarios plus random traffic against a queue-based reference.
module tb_dcache_rr_tag_arbiter;
    localparam int NP  = 5;
    localparam int SA  = 8;
    localparam int IW  = 12;
    localparam int TW  = 44;
    localparam int LW  = 128;
    localparam int EW  = 2 + TW + LW;
    localparam int BW  = LW / 8 + 2;
    localparam int LIM = 4;

    typedef struct {
        int                       cyc;
        int                       port;
        logic [SA-1:0][EW-1:0]    data;
        logic [SA-1:0]            hit;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NP-1:0][SA-1:0] req = '0;
    logic [NP-1:0][IW-1:0] addr = '0;
    logic [NP-1:0]         we = '0;
    logic [NP-1:0][EW-1:0] wdata = '0;
    logic [NP-1:0][BW-1:0] be = '0;
    logic [NP-1:0][TW-1:0] tag = '0;
    logic [NP-1:0]         gnt_o, rvalid_o;
    logic [SA-1:0][EW-1:0] rdata_o;
    logic [SA-1:0]         hit_way_o, sram_req_o;
    logic [IW-1:0]         sram_addr_o;
    logic                  sram_we_o;
    logic [EW-1:0]         sram_wdata_o;
    logic [BW-1:0]         sram_be_o;
    logic [SA-1:0][EW-1:0] sram_rdata = '0;

    dcache_rr_tag_arbiter dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata),
        .be_i(be), .tag_i(tag), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .hit_way_o(hit_way_o), .sram_req_o(sram_req_o), .sram_addr_o(sram_addr_o),
        .sram_we_o(sram_we_o), .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o),
        .sram_rdata_i(sram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nerr = 0;
    int nchk = 0;
    exp_t q[$];

    // Stimulus for the next cycle and directed-check hooks.
    logic [NP-1:0][SA-1:0] st_req;
    logic [NP-1:0][IW-1:0] st_addr;
    logic [NP-1:0]         st_we;
    logic [NP-1:0][EW-1:0] st_wdata;
    logic [NP-1:0][BW-1:0] st_be;
    logic                  st_rst;
    int                    dir_gnt = -2;
    int                    dir_hit = -1;
    logic                  force_vld = 1'b0;
    logic [TW-1:0]         force_tag;
    logic [NP-1:0]         pend_vld = '0;
    logic [NP-1:0][TW-1:0] pend_tag;
    int                    tag_ctr = 0;

    // Reference state: round-robin pointer, starvation counts, memory contents.
    int                    ptr = 1;
    int                    starve[NP];
    logic [EW-1:0]         rmem[16][SA];
    logic [EW-1:0]         smem[16][SA];

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] apply_be(logic [EW-1:0] old, logic [EW-1:0] nw, logic [BW-1:0] b);
        logic [EW-1:0] res;
        res = old;
        for (int i = 0; i < LW / 8; i++) if (b[i]) res[8*i +: 8] = nw[8*i +: 8];
        if (b[BW-2]) res[LW +: TW] = nw[LW +: TW];
        if (b[BW-1]) res[EW-2 +: 2] = nw[EW-2 +: 2];
        return res;
    endfunction

    function automatic int model_winner(logic [NP-1:0] r);
        int order[$];
        for (int k = 0; k < NP; k++) if ((ptr + k) % NP != 0) order.push_back((ptr + k) % NP);
        if (r[0]) begin
            foreach (order[j]) if (r[order[j]] && starve[order[j]] >= LIM) return order[j];
            return 0;
        end
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    // SRAM behaviour: one-cycle read latency, unselected ways return zero.
    always @(posedge clk) begin
        for (int w = 0; w < SA; w++) begin
            if (sram_req_o[w] && sram_we_o) begin
                smem[sram_addr_o[3:0]][w] <= apply_be(smem[sram_addr_o[3:0]][w], sram_wdata_o, sram_be_o);
                sram_rdata[w] <= '0;
            end else if (sram_req_o[w]) begin
                sram_rdata[w] <= smem[sram_addr_o[3:0]][w];
            end else begin
                sram_rdata[w] <= '0;
            end
        end
    end

    // Monitor: pops the expectation due this cycle whenever the DUT returns read data.
    initial begin
        exp_t e;
        logic [NP-1:0] rv;
        bit have;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                chk("stale_expectation", 256'(q[0].cyc), 256'(cyc));
                q.delete(0);
            end
            rv = '0;
            have = 1'b0;
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                rv[e.port] = 1'b1;
                have = 1'b1;
            end
            chk("rvalid", rvalid_o, rv);
            if (have) begin
                for (int w = 0; w < SA; w++) chk($sformatf("rdata_way%0d", w), rdata_o[w], e.data[w]);
                chk("hit_way", hit_way_o, e.hit);
            end else begin
                chk("hit_idle", hit_way_o, '0);
            end
        end
    end

    task automatic clear_stim();
        st_req = '0; st_addr = '0; st_we = '0; st_wdata = '0; st_be = '0; st_rst = 1'b0;
    endtask

    task automatic do_cycle();
        logic [NP-1:0] r;
        logic [NP-1:0] eg;
        logic [NP-1:0] dg;
        logic [TW-1:0] ctag;
        int w;
        int a;
        exp_t e;
        @(posedge clk);
        #1;
        if (st_rst) while (q.size() > 0 && q[0].cyc <= cyc) q.delete(0);
        rst = st_rst; req = st_req; addr = st_addr; we = st_we; wdata = st_wdata; be = st_be;
        for (int p = 0; p < NP; p++) begin
            tag[p] = pend_vld[p] ? pend_tag[p] : TW'({$urandom(), $urandom()});
            pend_vld[p] = 1'b0;
        end
        @(negedge clk);
        for (int p = 0; p < NP; p++) r[p] = |st_req[p];
        w = st_rst ? -1 : model_winner(r);
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", gnt_o, eg);
        if (dir_gnt != -2) begin
            dg = '0;
            if (dir_gnt >= 0) dg[dir_gnt] = 1'b1;
            chk("gnt_directed", gnt_o, dg);
        end
        if (dir_hit >= 0) chk("hit_directed", hit_way_o, 256'(dir_hit));
        if (w >= 0) begin
            chk("sram_req", sram_req_o, st_req[w]);
            chk("sram_addr", sram_addr_o, st_addr[w]);
            chk("sram_we", sram_we_o, st_we[w]);
            a = int'(st_addr[w][3:0]);
            if (st_we[w]) begin
                chk("sram_wdata", sram_wdata_o, st_wdata[w]);
                chk("sram_be", sram_be_o, st_be[w]);
                for (int k = 0; k < SA; k++)
                    if (st_req[w][k]) rmem[a][k] = apply_be(rmem[a][k], st_wdata[w], st_be[w]);
            end else begin
                if (force_vld) ctag = force_tag;
                else if ($urandom_range(0, 1) == 1) ctag = rmem[a][$urandom_range(0, SA-1)][LW +: TW];
                else ctag = {4'hF, 40'({$urandom(), $urandom()})};
                e.cyc = cyc + 1;
                e.port = w;
                for (int k = 0; k < SA; k++) begin
                    e.data[k] = st_req[w][k] ? rmem[a][k] : '0;
                    e.hit[k] = st_req[w][k] && rmem[a][k][EW-1] && (rmem[a][k][LW +: TW] == ctag);
                end
                q.push_back(e);
                pend_vld[w] = 1'b1;
                pend_tag[w] = ctag;
            end
        end else begin
            chk("sram_req_idle", sram_req_o, '0);
            chk("sram_we_idle", sram_we_o, 1'b0);
        end
        if (st_rst) begin
            ptr = 1;
            foreach (starve[i]) starve[i] = 0;
        end else begin
            for (int i = 1; i < NP; i++)
                starve[i] = (!r[i] || i == w) ? 0 : ((starve[i] < LIM) ? starve[i] + 1 : LIM);
            if (w > 0) ptr = (w == NP - 1) ? 1 : w + 1;
        end
        dir_gnt = -2;
        dir_hit = -1;
        force_vld = 1'b0;
    endtask

    task automatic rand_stim();
        clear_stim();
        for (int p = 0; p < NP; p++) begin
            st_addr[p] = IW'($urandom_range(0, 15));
            st_we[p] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) < 55) begin
                if (st_we[p]) st_req[p] = SA'(1) << $urandom_range(0, SA-1);
                else st_req[p] = SA'($urandom_range(1, (1 << SA) - 1));
            end
            tag_ctr++;
            st_wdata[p] = {2'($urandom_range(0, 3)), TW'(64'h100 + 64'(tag_ctr)),
                           {$urandom(), $urandom(), $urandom(), $urandom()}};
            st_be[p] = {1'($urandom_range(0, 1)), 1'b1, 16'($urandom())};
        end
        st_rst = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        foreach (starve[i]) starve[i] = 0;
        for (int a = 0; a < 16; a++)
            for (int k = 0; k < SA; k++) begin
                rmem[a][k] = '0;
                smem[a][k] = '0;
            end

        // Reset, then idle: nothing granted or returned.
        for (int i = 0; i < 6; i++) begin
            clear_stim();
            st_rst = (i < 3);
            dir_gnt = -1;
            do_cycle();
        end

        // Ports 1..3 reading continuously rotate 1,2,3.
        for (int i = 0; i < 9; i++) begin
            clear_stim();
            for (int p = 1; p <= 3; p++) begin st_req[p] = 8'hFF; st_addr[p] = IW'(p); end
            dir_gnt = 1 + (i % 3);
            do_cycle();
        end
        clear_stim();
        do_cycle();

        // Port 0 vs port 2: four port-0 grants, then the starved port 2.
        for (int i = 0; i < 10; i++) begin
            clear_stim();
            st_req[0] = 8'hFF; st_req[2] = 8'hFF; st_addr[0] = 12'd9; st_addr[2] = 12'd10;
            dir_gnt = ((i % 5) == 4) ? 2 : 0;
            do_cycle();
        end
        clear_stim();
        do_cycle();

        // Write tag 0x5A into way 3 of index 7, then read it back for a hit.
        clear_stim();
        st_req[1] = 8'b0000_1000; st_we[1] = 1'b1; st_addr[1] = 12'd7; st_be[1] = '1;
        st_wdata[1] = {1'b1, 1'b0, 44'h5A, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C};
        dir_gnt = 1;
        do_cycle();
        clear_stim();
        st_req[1] = 8'hFF; st_addr[1] = 12'd7; force_vld = 1'b1; force_tag = 44'h5A; dir_gnt = 1;
        do_cycle();
        clear_stim();
        dir_hit = 8'b0000_1000;
        do_cycle();

        // Read then write the same index: the read returns the pre-write entry.
        clear_stim();
        st_req[2] = 8'hFF; st_addr[2] = 12'd7; force_vld = 1'b1; force_tag = 44'h5A; dir_gnt = 2;
        do_cycle();
        clear_stim();
        st_req[2] = 8'b0000_1000; st_we[2] = 1'b1; st_addr[2] = 12'd7; st_be[2] = '1;
        st_wdata[2] = {1'b1, 1'b1, 44'h77, 128'h1111_2222_3333_4444_5555_6666_7777_8888};
        dir_hit = 8'b0000_1000; dir_gnt = 2;
        do_cycle();
        clear_stim();
        st_req[2] = 8'hFF; st_addr[2] = 12'd7; force_vld = 1'b1; force_tag = 44'h77;
        do_cycle();
        clear_stim();
        dir_hit = 8'b0000_1000;
        do_cycle();

        // Reset right after a read grant: no rvalid, pointer back to port 1.
        clear_stim();
        st_req[1] = 8'hFF; st_addr[1] = 12'd5; dir_gnt = 1;
        do_cycle();
        clear_stim();
        st_rst = 1'b1; st_req[3] = 8'hFF; dir_gnt = -1;
        do_cycle();
        clear_stim();
        for (int p = 1; p < NP; p++) begin st_req[p] = 8'hFF; st_addr[p] = IW'(p); end
        dir_gnt = 1;
        do_cycle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rand_stim();
            do_cycle();
        end
        for (int i = 0; i < 3; i++) begin
            clear_stim();
            do_cycle();
        end
        chk("pending_reads", 256'(q.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
